// File: rtl/riscv_pkg.sv
// Shared core definitions: data-memory op encodings and machine-timer register map.
package riscv_pkg;

  localparam logic [1:0]  DMEM_SIZE_NONE = 2'd0;
  localparam logic [1:0]  DMEM_SIZE_BYTE = 2'd1;
  localparam logic [1:0]  DMEM_SIZE_HALF = 2'd2;
  localparam logic [1:0]  DMEM_SIZE_WORD = 2'd3;
  localparam int unsigned DMEM_STORE_BIT = 2;

  localparam logic [3:0]  TIMER_OFF_MTIME_LO    = 4'h0;
  localparam logic [3:0]  TIMER_OFF_MTIME_HI    = 4'h4;
  localparam logic [3:0]  TIMER_OFF_MTIMECMP_LO = 4'h8;
  localparam logic [3:0]  TIMER_OFF_MTIMECMP_HI = 4'hC;

  localparam logic [31:0] TIMER_BASE = 32'h0000_8000;

  typedef enum logic [1:0] {
    TIMER_MTIME_LO    = TIMER_OFF_MTIME_LO[3:2],
    TIMER_MTIME_HI    = TIMER_OFF_MTIME_HI[3:2],
    TIMER_MTIMECMP_LO = TIMER_OFF_MTIMECMP_LO[3:2],
    TIMER_MTIMECMP_HI = TIMER_OFF_MTIMECMP_HI[3:2]
  } timer_word_e;

endpackage

// File: rtl/riscv_timer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE cycles; PRESCALE=1 yields a constant tick.
module riscv_timer_prescaler
  import riscv_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // With PRESCALE=1 the count is pinned at 0 == LAST, so tick folds to a constant.
  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

endmodule

// File: rtl/riscv_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with level timer_irq.
// Optional RISCV_TIMER_SNAPSHOT_EN: a load of mtime lo snapshots mtime hi for a tear-free hi read.
module riscv_timer
  import riscv_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] BASE     = TIMER_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dmem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        timer_irq
);

  logic        tick;
  logic        sel;
  logic        load;
  logic        store;
  timer_word_e word;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_view;
  logic [31:0] read_word;
  logic [1:0]  unused_addr;

  assign unused_addr = addr[1:0];

  assign sel   = (dmem_op[1:0] != DMEM_SIZE_NONE) && (addr[31:4] == BASE[31:4]);
  assign word  = timer_word_e'(addr[3:2]);
  assign load  = sel && !dmem_op[DMEM_STORE_BIT];
  assign store = sel && dmem_op[DMEM_STORE_BIT] && (dmem_op[1:0] == DMEM_SIZE_WORD);

  riscv_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef RISCV_TIMER_SNAPSHOT_EN
  logic [31:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                shadow <= '0;
    else if (load && word == TIMER_MTIME_LO) shadow <= mtime[63:32];
  end

  assign mtime_hi_view = shadow;
`else
  assign mtime_hi_view = mtime[63:32];
`endif

  always_comb begin
    read_word = '0;
    case (word)
      TIMER_MTIME_LO:    read_word = mtime[31:0];
      TIMER_MTIME_HI:    read_word = mtime_hi_view;
      TIMER_MTIMECMP_LO: read_word = mtimecmp[31:0];
      TIMER_MTIMECMP_HI: read_word = mtimecmp[63:32];
      default:           read_word = '0;
    endcase
  end

  // A store to either mtime half beats the tick; the other half is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  mtime <= '0;
    else if (store && word == TIMER_MTIME_LO) mtime[31:0]  <= wdata;
    else if (store && word == TIMER_MTIME_HI) mtime[63:32] <= wdata;
    else if (tick)                            mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     mtimecmp <= '1;
    else if (store && word == TIMER_MTIMECMP_LO) mtimecmp[31:0]  <= wdata;
    else if (store && word == TIMER_MTIMECMP_HI) mtimecmp[63:32] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      timer_irq   <= 1'b0;
    end else begin
      rdata_valid <= load;
      if (load) rdata <= read_word;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_riscv_timer.sv
// Bench for riscv_timer: PRESCALE=1 and PRESCALE=4 instances on one bus against a cycle-level model.
module tb_riscv_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dmem_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a [2];
  logic        valid_a [2];
  logic        irq_a   [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  logic [63:0] m_mtime  [2];
  logic [63:0] m_cmp    [2];
  logic [31:0] m_shadow [2];
  logic [31:0] m_rdata  [2];
  logic        m_valid  [2];
  logic        m_irq    [2];
  int unsigned m_edges  [2];

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b111;
  localparam logic [2:0] OP_SB   = 3'b101;

  riscv_timer #(.PRESCALE(1), .BASE(32'h8000)) u_p1 (
    .clk(clk), .rst(rst), .dmem_op(dmem_op), .addr(addr), .wdata(wdata),
    .rdata(rdata_a[0]), .rdata_valid(valid_a[0]), .timer_irq(irq_a[0])
  );

  riscv_timer #(.PRESCALE(4), .BASE(32'h8000)) u_p4 (
    .clk(clk), .rst(rst), .dmem_op(dmem_op), .addr(addr), .wdata(wdata),
    .rdata(rdata_a[1]), .rdata_valid(valid_a[1]), .timer_irq(irq_a[1])
  );

  always #5 clk = ~clk;

  function automatic int unsigned period(input int unsigned i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mtime[i]  = '0;
      m_cmp[i]    = '1;
      m_shadow[i] = '0;
      m_rdata[i]  = '0;
      m_valid[i]  = 1'b0;
      m_irq[i]    = 1'b0;
      m_edges[i]  = 0;
    end
  endtask

  // One clock edge of the architectural behaviour, applied to both instances.
  task automatic model_edge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    bit          sel;
    bit          tick;
    int unsigned idx;
    sel = (op[1:0] != 2'd0) && (a[31:4] == 28'h0000800);
    idx = a[3:2];
    for (int i = 0; i < 2; i++) begin
      tick = ((m_edges[i] % period(i)) == period(i) - 1);
      m_edges[i]++;
      m_irq[i]   = (m_mtime[i] >= m_cmp[i]);
      m_valid[i] = sel && !op[2];
      if (m_valid[i]) begin
        case (idx)
          0: begin
            m_rdata[i]  = m_mtime[i][31:0];
            m_shadow[i] = m_mtime[i][63:32];
          end
`ifdef RISCV_TIMER_SNAPSHOT_EN
          1: m_rdata[i] = m_shadow[i];
`else
          1: m_rdata[i] = m_mtime[i][63:32];
`endif
          2: m_rdata[i] = m_cmp[i][31:0];
          default: m_rdata[i] = m_cmp[i][63:32];
        endcase
      end
      if (sel && op == OP_SW && idx == 0)      m_mtime[i][31:0]  = d;
      else if (sel && op == OP_SW && idx == 1) m_mtime[i][63:32] = d;
      else if (tick)                           m_mtime[i] = m_mtime[i] + 64'd1;
      if (sel && op == OP_SW && idx == 2) m_cmp[i][31:0]  = d;
      if (sel && op == OP_SW && idx == 3) m_cmp[i][63:32] = d;
    end
  endtask

  task automatic compare_all();
    check("valid_p1", valid_a[0], m_valid[0]);
    check("rdata_p1", rdata_a[0], m_rdata[0]);
    check("irq_p1",   irq_a[0],   m_irq[0]);
    check("valid_p4", valid_a[1], m_valid[1]);
    check("rdata_p4", rdata_a[1], m_rdata[1]);
    check("irq_p4",   irq_a[1],   m_irq[1]);
  endtask

  // Drive at the falling edge, model the rising edge, sample at the next falling edge.
  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    dmem_op = op;
    addr    = a;
    wdata   = d;
    @(posedge clk);
    model_edge(op, a, d);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] v0;
    logic [31:0] v1;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned r;
    int unsigned guard;

    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    repeat (10) step(OP_IDLE, 32'h0, 32'h0);
    step(OP_LW, 32'h8000, 32'h0);
    check("cycle10_mtime", rdata_a[0], 32'd10);
    check("cycle10_valid", valid_a[0], 1'b1);

    step(OP_SW, 32'h8000, 32'h0);
    step(OP_SW, 32'h8004, 32'h0);
    step(OP_SW, 32'h8008, 32'd5);
    step(OP_SW, 32'h800C, 32'h0);
    repeat (12) step(OP_IDLE, 32'h0, 32'h0);
    check("irq_raised", irq_a[0], 1'b1);
    step(OP_SW, 32'h8008, 32'd100);
    step(OP_IDLE, 32'h0, 32'h0);
    check("irq_cleared", irq_a[0], 1'b0);

    step(OP_SW, 32'h8004, 32'h0);
    step(OP_SW, 32'h8000, 32'hFFFF_FFFF);
    step(OP_IDLE, 32'h0, 32'h0);
    step(OP_LW, 32'h8000, 32'h0);
    check("carry_lo", rdata_a[0], 32'h0);
    step(OP_LW, 32'h8004, 32'h0);
    check("carry_hi", rdata_a[0], 32'h1);

    step(OP_SW, 32'h8004, 32'hFFFF_FFFF);
    step(OP_SW, 32'h8000, 32'hFFFF_FFFF);
    step(OP_IDLE, 32'h0, 32'h0);
    step(OP_LW, 32'h8000, 32'h0);
    check("wrap_lo", rdata_a[0], 32'h0);
    step(OP_LW, 32'h8004, 32'h0);
    check("wrap_hi", rdata_a[0], 32'h0);

    step(OP_SW, 32'h8004, 32'd7);
    step(OP_SW, 32'h8000, 32'hFFFF_FFFF);
    step(OP_LW, 32'h8000, 32'h0);
    check("snap_lo", rdata_a[0], 32'hFFFF_FFFF);
    step(OP_LW, 32'h8004, 32'h0);
`ifdef RISCV_TIMER_SNAPSHOT_EN
    check("snap_hi", rdata_a[0], 32'd7);
`else
    check("snap_hi", rdata_a[0], 32'd8);
`endif

    step(OP_SW, 32'h8000, 32'h0);
    step(OP_SW, 32'h8004, 32'h0);
    step(OP_LW, 32'h8000, 32'h0);
    v0 = rdata_a[1];
    repeat (11) step(OP_IDLE, 32'h0, 32'h0);
    step(OP_LW, 32'h8000, 32'h0);
    v1 = rdata_a[1];
    check("p4_advance", v1 - v0, 32'd3);
    guard = 0;
    while ((m_edges[1] % 4) != 3 && guard < 8) begin
      step(OP_IDLE, 32'h0, 32'h0);
      guard++;
    end
    step(OP_SW, 32'h8000, 32'h1234);
    step(OP_LW, 32'h8000, 32'h0);
    check("p4_tick_store", rdata_a[1], 32'h1234);

    step(OP_SB, 32'h8008, 32'h0);
    step(OP_SW, 32'h8010, 32'h0);
    step(OP_LW, 32'h8010, 32'h0);
    check("outside_valid", valid_a[0], 1'b0);
    step(OP_LB, 32'h8009, 32'h0);
    check("byte_store_dropped", rdata_a[0], 32'd100);

    for (int n = 0; n < 2000; n++) begin
      r  = $urandom_range(0, 9);
      op = 3'($urandom_range(0, 7));
      if (r < 3) op = OP_SW;
      if (r == 3) op = OP_IDLE;
      a = 32'h8000 | ($urandom & 32'hF);
      if (r == 8) a = 32'h8010 | ($urandom & 32'hF);
      if (r == 9) a = $urandom;
      if (a[2]) d = $urandom_range(0, 2);
      else if ($urandom_range(0, 3) == 0) d = $urandom;
      else d = $urandom_range(0, 400);
      step(op, a, d);
    end

    @(negedge clk);
    dmem_op = OP_LW;
    addr    = 32'h8008;
    #2 rst  = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    check("reset_load_valid", valid_a[0], 1'b0);
    rst = 1'b0;
    step(OP_LW, 32'h8008, 32'h0);
    check("reset_cmp_lo", rdata_a[0], 32'hFFFF_FFFF);
    step(OP_LW, 32'h800C, 32'h0);
    check("reset_cmp_hi", rdata_a[1], 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
